// File: rtl/sc_speedscheduler_pkg.sv
// sc_speedscheduler_pkg: shared state encoding and sizing helpers for the speed scheduler.
//   sc_state_t           : RELOAD / RUN / PAUSE scheduler states
//   sc_period(base, k)   : tick period in cycles at speed level k (base >> k)
//   sc_level_width(n)    : bits needed to hold a level index for n levels
package sc_speedscheduler_pkg;

    typedef enum logic [1:0] {
        RELOAD,
        RUN,
        PAUSE
    } sc_state_t;

    function automatic longint sc_period(input longint base, input int k);
        return base >> k;
    endfunction

    function automatic int sc_level_width(input int levels);
        return (levels > 1) ? $clog2(levels) : 1;
    endfunction

endpackage

// File: rtl/sc_speedscheduler_edgedetect.sv
// sc_speedscheduler_edgedetect: two-flop falling-edge detector for an active-low button.
//   SC_SPEEDSCHEDULER_EDGEDETECT_CLOCK_50      in  system clock
//   SC_SPEEDSCHEDULER_EDGEDETECT_RESET_InHigh  in  asynchronous active-high reset
//   SC_SPEEDSCHEDULER_EDGEDETECT_button_InLow  in  debounced button level
//   SC_SPEEDSCHEDULER_EDGEDETECT_request_Out   out one-cycle pulse per falling edge
module sc_speedscheduler_edgedetect (
    input  logic SC_SPEEDSCHEDULER_EDGEDETECT_CLOCK_50,
    input  logic SC_SPEEDSCHEDULER_EDGEDETECT_RESET_InHigh,
    input  logic SC_SPEEDSCHEDULER_EDGEDETECT_button_InLow,
    output logic SC_SPEEDSCHEDULER_EDGEDETECT_request_Out
);
    logic s1;
    logic s2;

    // Flops reset high so a button held released through reset never fires.
    always_ff @(posedge SC_SPEEDSCHEDULER_EDGEDETECT_CLOCK_50 or posedge SC_SPEEDSCHEDULER_EDGEDETECT_RESET_InHigh) begin
        if (SC_SPEEDSCHEDULER_EDGEDETECT_RESET_InHigh) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= SC_SPEEDSCHEDULER_EDGEDETECT_button_InLow;
            s2 <= s1;
        end
    end

    assign SC_SPEEDSCHEDULER_EDGEDETECT_request_Out = s2 & ~s1;

endmodule

// File: rtl/sc_speedscheduler.sv
// sc_speedscheduler: power-of-two rate scheduler emitting a one-cycle tick per period.
//   SC_SPEEDSCHEDULER_CLOCK_50      in  system clock
//   SC_SPEEDSCHEDULER_RESET_InHigh  in  asynchronous active-high reset
//   SC_SPEEDSCHEDULER_faster_InLow  in  button, falling edge requests next faster level
//   SC_SPEEDSCHEDULER_slower_InLow  in  button, falling edge requests next slower level
//   SC_SPEEDSCHEDULER_pause_InLow   in  low freezes the counter
//   SC_SPEEDSCHEDULER_tick_Out      out registered one-cycle tick, once per period
//   SC_SPEEDSCHEDULER_level_OutBUS  out current speed level
//   SC_SPEEDSCHEDULER_count_OutBUS  out current counter value
module sc_speedscheduler
    import sc_speedscheduler_pkg::*;
#(
    parameter int SPEEDSCHEDULER_DATAWIDTH   = 28,
    parameter int SPEEDSCHEDULER_LEVELS      = 8,
    parameter int SPEEDSCHEDULER_BASEPERIOD  = 50000000,
    parameter int SPEEDSCHEDULER_INITLEVEL   = 0
) (
    input  logic SC_SPEEDSCHEDULER_CLOCK_50,
    input  logic SC_SPEEDSCHEDULER_RESET_InHigh,
    input  logic SC_SPEEDSCHEDULER_faster_InLow,
    input  logic SC_SPEEDSCHEDULER_slower_InLow,
    input  logic SC_SPEEDSCHEDULER_pause_InLow,
    output logic SC_SPEEDSCHEDULER_tick_Out,
    output logic [sc_level_width(SPEEDSCHEDULER_LEVELS)-1:0] SC_SPEEDSCHEDULER_level_OutBUS,
    output logic [SPEEDSCHEDULER_DATAWIDTH-1:0] SC_SPEEDSCHEDULER_count_OutBUS
);
    localparam int DW = SPEEDSCHEDULER_DATAWIDTH;
    localparam int LW = sc_level_width(SPEEDSCHEDULER_LEVELS);
    localparam logic [LW-1:0] LEVEL_MAX  = LW'(SPEEDSCHEDULER_LEVELS - 1);
    localparam logic [LW-1:0] LEVEL_INIT = LW'(SPEEDSCHEDULER_INITLEVEL);

    if (sc_period(longint'(SPEEDSCHEDULER_BASEPERIOD), SPEEDSCHEDULER_LEVELS - 1) < 2 ||
        longint'(SPEEDSCHEDULER_BASEPERIOD) > (longint'(1) << DW)) begin : g_param_check
        $error("sc_speedscheduler: fastest period below 2 or base period exceeds counter range");
    end

    sc_state_t       state_q;
    sc_state_t       state_d;
    logic [LW-1:0]   level_q;
    logic [LW-1:0]   level_d;
    logic [DW-1:0]   count_q;
    logic [DW-1:0]   count_d;
    logic [DW-1:0]   period_m1;
    logic            tick_q;
    logic            tick_d;
    logic            req_faster;
    logic            req_slower;
    logic            go_up;
    logic            go_down;

    sc_speedscheduler_edgedetect u_faster (
        .SC_SPEEDSCHEDULER_EDGEDETECT_CLOCK_50     (SC_SPEEDSCHEDULER_CLOCK_50),
        .SC_SPEEDSCHEDULER_EDGEDETECT_RESET_InHigh (SC_SPEEDSCHEDULER_RESET_InHigh),
        .SC_SPEEDSCHEDULER_EDGEDETECT_button_InLow (SC_SPEEDSCHEDULER_faster_InLow),
        .SC_SPEEDSCHEDULER_EDGEDETECT_request_Out  (req_faster)
    );

    sc_speedscheduler_edgedetect u_slower (
        .SC_SPEEDSCHEDULER_EDGEDETECT_CLOCK_50     (SC_SPEEDSCHEDULER_CLOCK_50),
        .SC_SPEEDSCHEDULER_EDGEDETECT_RESET_InHigh (SC_SPEEDSCHEDULER_RESET_InHigh),
        .SC_SPEEDSCHEDULER_EDGEDETECT_button_InLow (SC_SPEEDSCHEDULER_slower_InLow),
        .SC_SPEEDSCHEDULER_EDGEDETECT_request_Out  (req_slower)
    );

    // Simultaneous requests cancel; saturated requests are dropped without a reload.
    assign go_up     = req_faster & ~req_slower & (level_q != LEVEL_MAX);
    assign go_down   = req_slower & ~req_faster & (level_q != '0);
    assign period_m1 = DW'(sc_period(longint'(SPEEDSCHEDULER_BASEPERIOD), int'(level_q)) - 1);

    always_ff @(posedge SC_SPEEDSCHEDULER_CLOCK_50 or posedge SC_SPEEDSCHEDULER_RESET_InHigh) begin
        if (SC_SPEEDSCHEDULER_RESET_InHigh) begin
            state_q <= RELOAD;
            level_q <= LEVEL_INIT;
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        count_d = count_q;
        tick_d  = 1'b0;
        // A level change outranks pause and tick so the new rate starts from a clean period.
        if (state_q != RELOAD && (go_up || go_down)) begin
            level_d = go_up ? level_q + LW'(1) : level_q - LW'(1);
            count_d = '0;
            state_d = RELOAD;
        end else begin
            case (state_q)
                RELOAD: begin
                    count_d = '0;
                    state_d = SC_SPEEDSCHEDULER_pause_InLow ? RUN : PAUSE;
                end
                RUN: begin
                    if (!SC_SPEEDSCHEDULER_pause_InLow) begin
                        state_d = PAUSE;
                    end else begin
                        tick_d  = (count_q == period_m1);
                        count_d = (count_q == period_m1) ? '0 : count_q + DW'(1);
                    end
                end
                PAUSE: state_d = SC_SPEEDSCHEDULER_pause_InLow ? RUN : PAUSE;
                default: state_d = RELOAD;
            endcase
        end
    end

    assign SC_SPEEDSCHEDULER_tick_Out     = tick_q;
    assign SC_SPEEDSCHEDULER_level_OutBUS = level_q;
    assign SC_SPEEDSCHEDULER_count_OutBUS = count_q;

endmodule

// File: tb/tb_sc_speedscheduler.sv
// tb_sc_speedscheduler: directed bench with a tick-time scoreboard for sc_speedscheduler.
module tb_sc_speedscheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       faster;
    logic       slower;
    logic       pause;
    logic       tick;
    logic [1:0] level;
    logic [7:0] count;

    int n_assert = 0;
    int n_fail   = 0;
    int e        = 0;
    int r;
    int n;
    int exp_edge;
    int tick_q[$];

    sc_speedscheduler #(
        .SPEEDSCHEDULER_DATAWIDTH  (8),
        .SPEEDSCHEDULER_LEVELS     (4),
        .SPEEDSCHEDULER_BASEPERIOD (16),
        .SPEEDSCHEDULER_INITLEVEL  (0)
    ) dut (
        .SC_SPEEDSCHEDULER_CLOCK_50     (clk),
        .SC_SPEEDSCHEDULER_RESET_InHigh (rst),
        .SC_SPEEDSCHEDULER_faster_InLow (faster),
        .SC_SPEEDSCHEDULER_slower_InLow (slower),
        .SC_SPEEDSCHEDULER_pause_InLow  (pause),
        .SC_SPEEDSCHEDULER_tick_Out     (tick),
        .SC_SPEEDSCHEDULER_level_OutBUS (level),
        .SC_SPEEDSCHEDULER_count_OutBUS (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic push_ticks(input int first, input int per, input int cnt);
        for (int i = 0; i < cnt; i++) tick_q.push_back(first + i * per);
    endtask

    // Advance edge by edge; every observed tick is matched against the next expected edge.
    task automatic step(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            @(posedge clk);
            #1;
            e++;
            if (tick === 1'b1) begin
                if (tick_q.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $error("FAIL tick_unexpected observed=edge %0d expected=no tick", e);
                end else begin
                    exp_edge = tick_q.pop_front();
                    chk("tick_edge", e, exp_edge);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; faster = 1'b1; slower = 1'b1; pause = 1'b1;
        step(2);
        chk("reset_tick", tick, 0);
        chk("reset_count", count, 0);
        chk("reset_level", level, 0);
        rst = 1'b0;
        r = e;
        push_ticks(r + 17, 16, 2);
        step(1);
        chk("reload_count", count, 0);
        step(4);
        chk("run_count4", count, 4);
        step(36);
        chk("level0", level, 0);
        // one faster press at count 9
        faster = 1'b0;
        step(1);
        n = e;
        chk("press_count9", count, 9);
        step(1);
        chk("faster_level1", level, 1);
        chk("faster_count0", count, 0);
        faster = 1'b1;
        push_ticks(n + 10, 8, 3);
        step(1);
        chk("reload_run_count0", count, 0);
        step(24);
        // faster to level 2 then 3
        faster = 1'b0;
        step(1);
        n = e;
        step(1);
        chk("faster_level2", level, 2);
        chk("faster2_count0", count, 0);
        faster = 1'b1;
        push_ticks(n + 6, 4, 2);
        step(9);
        faster = 1'b0;
        step(1);
        n = e;
        step(1);
        chk("faster_level3", level, 3);
        faster = 1'b1;
        push_ticks(n + 4, 2, 9);
        step(8);
        // fourth press at saturation: no reload, phase kept
        faster = 1'b0;
        step(2);
        chk("sat_level3", level, 3);
        chk("sat_no_reload", count, 1);
        faster = 1'b1;
        step(10);
        // reset mid-operation at level 3
        rst = 1'b1;
        #1;
        chk("midreset_tick", tick, 0);
        chk("midreset_count", count, 0);
        chk("midreset_level", level, 0);
        chk("ticks_pending_a", tick_q.size(), 0);
        step(1);
        rst = 1'b0;
        r = e;
        push_ticks(r + 17, 16, 2);
        // slower at level 0 is ignored
        step(20);
        slower = 1'b0;
        step(2);
        chk("slower_level0", level, 0);
        chk("slower_count5", count, 5);
        slower = 1'b1;
        step(16);
        // pause low for 10 edges at count 5
        chk("pre_pause_count", count, 5);
        pause = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("pause_hold", count, 5);
        end
        pause = 1'b1;
        step(1);
        chk("pause_resume_hold", count, 5);
        step(1);
        chk("pause_resume_count6", count, 6);
        push_ticks(r + 60, 16, 2);
        step(29);
        // both buttons fall together
        faster = 1'b0;
        slower = 1'b0;
        step(2);
        chk("both_level", level, 0);
        chk("both_count", count, 5);
        faster = 1'b1;
        slower = 1'b1;
        step(7);
        chk("pre_reset_count12", count, 12);
        rst = 1'b1;
        #1;
        chk("reset12_tick", tick, 0);
        chk("reset12_count", count, 0);
        chk("reset12_level", level, 0);
        chk("ticks_pending_b", tick_q.size(), 0);
        step(2);
        rst = 1'b0;
        step(1);
        chk("rerun_count0", count, 0);
        step(1);
        chk("rerun_count1", count, 1);
        chk("ticks_pending_end", tick_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
